// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the SDRAM slot arbiter and its refresh timer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sdram_arb_pkg;

    // Requester bit positions in req/grant/ack
    localparam int REQ_CPU  = 0;
    localparam int REQ_HOST = 1;
    localparam int REQ_RTG  = 2;
    localparam int REQ_AUD  = 3;
    localparam int NUM_REQ  = 4;
    localparam int NUM_RR   = 3;   // cpu, host, rtg share slots round-robin

    // Default timing/priority knobs
    localparam int DEF_REFRESH_INTERVAL = 890;  // 7.8 us at 114 MHz
    localparam int DEF_REFRESH_URGENT   = 4;
    localparam int DEF_STARVE_LIMIT     = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_REFRESH = 2'd2
    } arb_state_e;

    // Round-robin index: (ptr + k) mod 3, for ptr in 0..2 and k in 0..2
    function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= NUM_RR) s = s - NUM_RR;
        return 2'(s);
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval down-counter plus saturating count of refreshes still owed.
// Latency: refresh_pending updates one cycle after a tick or consume.
// Backpressure: none; a consume in the same cycle as a tick leaves the count unchanged.
module sdram_refresh_timer
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int CNT_W            = 3
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             consume,
    output logic [CNT_W-1:0] refresh_pending
);

    localparam int                TMR_W    = $clog2(REFRESH_INTERVAL);
    localparam logic [TMR_W-1:0]  RELOAD   = TMR_W'(REFRESH_INTERVAL - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0]  PEND_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  PEND_MAX = '1;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             tick;

    // Next timer value and pending count; tick fires while the timer sits at zero
    always_comb begin
        tick   = (tmr_q == '0);
        tmr_d  = tick ? RELOAD : (tmr_q - TMR_ONE);
        pend_d = pend_q;
        if (tick && !consume) begin
            if (pend_q != PEND_MAX) pend_d = pend_q + PEND_ONE;
        end else if (consume && !tick) begin
            if (pend_q != '0) pend_d = pend_q - PEND_ONE;
        end
    end

    // Timer and pending-count registers
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q  <= RELOAD;
            pend_q <= '0;
        end else begin
            tmr_q  <= tmr_d;
            pend_q <= pend_d;
        end
    end

    assign refresh_pending = pend_q;

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Picks the next SDRAM slot owner (refresh, audio, or round-robin cpu/host/rtg with starvation promotion).
// Latency: grant/grant_refresh/busy valid the cycle after slot_start; ack one cycle after slot_done.
// Backpressure: decisions only on slot_start in IDLE; grant held until slot_done regardless of req.
module sdram_slot_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int REFRESH_URGENT   = DEF_REFRESH_URGENT,
    parameter int STARVE_LIMIT     = DEF_STARVE_LIMIT,
    parameter int CNT_W            = 3
) (
    input  logic               sysclk,
    input  logic               reset_n,
    input  logic               slot_start,
    input  logic               slot_done,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_refresh,
    output logic [NUM_REQ-1:0] ack,
    output logic               busy,
    output logic [CNT_W-1:0]   refresh_pending,
    output logic               starve_hit
);

    localparam logic [CNT_W-1:0] URG_CNT = CNT_W'(REFRESH_URGENT);
    localparam logic [CNT_W-1:0] LIM_CNT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               hit_q, hit_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   starve_q [NUM_RR];
    logic [CNT_W-1:0]   starve_d [NUM_RR];

    logic               consume;
    logic               win_vld;
    logic [1:0]         win_idx;
    logic [1:0]         scan_idx;

    sdram_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .CNT_W            (CNT_W)
    ) u_refresh_timer (
        .sysclk          (sysclk),
        .reset_n         (reset_n),
        .consume         (consume),
        .refresh_pending (refresh_pending)
    );

    // Slot decision, slot completion and starvation bookkeeping
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ack_d    = '0;
        hit_d    = 1'b0;
        ptr_d    = ptr_q;
        starve_d = starve_q;
        consume  = 1'b0;
        win_vld  = 1'b0;
        win_idx  = 2'd0;
        scan_idx = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (slot_start) begin
                    if (refresh_pending >= URG_CNT) begin
                        state_d = ST_REFRESH;
                        consume = 1'b1;
                    end else begin
                        // Starved round-robin requesters outrank audio; ties go in pointer order
                        for (int k = 0; k < NUM_RR; k++) begin
                            scan_idx = rr_idx(ptr_q, k);
                            if (!win_vld && req[scan_idx] && (starve_q[scan_idx] >= LIM_CNT)) begin
                                win_vld = 1'b1;
                                win_idx = scan_idx;
                            end
                        end
                        if (win_vld) begin
                            hit_d = 1'b1;
                        end else if (req[REQ_AUD]) begin
                            win_vld = 1'b1;
                            win_idx = 2'(REQ_AUD);
                        end else begin
                            for (int k = 0; k < NUM_RR; k++) begin
                                scan_idx = rr_idx(ptr_q, k);
                                if (!win_vld && req[scan_idx]) begin
                                    win_vld = 1'b1;
                                    win_idx = scan_idx;
                                end
                            end
                            if (win_vld) ptr_d = rr_idx(win_idx, 1);
                        end

                        if (win_vld) begin
                            state_d = ST_GRANT;
                            grant_d = 4'b0001 << win_idx;
                        end else if (refresh_pending != '0) begin
                            state_d = ST_REFRESH;
                            consume = 1'b1;
                        end
                    end

                    // Every decision ages the requesters that lost and resets the rest
                    for (int i = 0; i < NUM_RR; i++) begin
                        if (!req[i] || (win_vld && (win_idx == 2'(i)))) begin
                            starve_d[i] = '0;
                        end else if (starve_q[i] != CNT_MAX) begin
                            starve_d[i] = starve_q[i] + CNT_ONE;
                        end
                    end
                end
            end
            ST_GRANT: begin
                if (slot_done) begin
                    state_d = ST_IDLE;
                    ack_d   = grant_q;
                    grant_d = '0;
                end
            end
            ST_REFRESH: begin
                if (slot_done) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            hit_q    <= 1'b0;
            ptr_q    <= 2'(REQ_CPU);
            starve_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            hit_q    <= hit_d;
            ptr_q    <= ptr_d;
            starve_q <= starve_d;
        end
    end

    assign grant         = grant_q;
    assign grant_refresh = (state_q == ST_REFRESH);
    assign busy          = (state_q != ST_IDLE);
    assign ack           = ack_q;
    assign starve_hit    = hit_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: model advances on each sysclk rising edge; outputs compared on falling edges.
// Backpressure: n/a.
module tb_sdram_slot_arbiter;

    localparam int RI   = 16;
    localparam int URG  = 4;
    localparam int LIM  = 6;
    localparam int CW   = 3;
    localparam int PMAX = 7;

    logic          sysclk     = 1'b0;
    logic          reset_n    = 1'b1;
    logic          slot_start = 1'b0;
    logic          slot_done  = 1'b0;
    logic [3:0]    req        = 4'b0000;
    logic [3:0]    grant;
    logic          grant_refresh;
    logic [3:0]    ack;
    logic          busy;
    logic [CW-1:0] refresh_pending;
    logic          starve_hit;

    always #5 sysclk = ~sysclk;

    sdram_slot_arbiter #(
        .REFRESH_INTERVAL (RI),
        .REFRESH_URGENT   (URG),
        .STARVE_LIMIT     (LIM),
        .CNT_W            (CW)
    ) dut (
        .sysclk          (sysclk),
        .reset_n         (reset_n),
        .slot_start      (slot_start),
        .slot_done       (slot_done),
        .req             (req),
        .grant           (grant),
        .grant_refresh   (grant_refresh),
        .ack             (ack),
        .busy            (busy),
        .refresh_pending (refresh_pending),
        .starve_hit      (starve_hit)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: mode 0 = no slot, 1 = requester slot (m_who), 2 = refresh slot
    int m_mode = 0;
    int m_who  = 0;
    int m_pend = 0;
    int m_edges = 0;
    int m_ptr  = 0;
    int m_ack  = 0;
    int m_hit  = 0;
    int m_starve [3] = '{0, 0, 0};

    task automatic model_step(input logic s, input logic d, input logic [3:0] r);
        int  win;
        bit  refr, tick, cons;
        m_edges++;
        tick = ((m_edges % RI) == 0);
        win  = -1;
        refr = 0;
        cons = 0;
        m_ack = 0;
        m_hit = 0;
        if (m_mode == 0 && s) begin
            if (m_pend >= URG) begin
                refr = 1;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    int i;
                    i = (m_ptr + k) % 3;
                    if (win < 0 && r[i] && m_starve[i] >= LIM) win = i;
                end
                if (win >= 0) begin
                    m_hit = 1;
                end else if (r[3]) begin
                    win = 3;
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        int i;
                        i = (m_ptr + k) % 3;
                        if (win < 0 && r[i]) win = i;
                    end
                    if (win >= 0) m_ptr = (win + 1) % 3;
                end
                if (win < 0 && m_pend > 0) refr = 1;
            end
            for (int i = 0; i < 3; i++) begin
                if (!r[i] || win == i) m_starve[i] = 0;
                else if (m_starve[i] < PMAX) m_starve[i] = m_starve[i] + 1;
            end
            if (refr) begin
                m_mode = 2;
                cons   = 1;
            end else if (win >= 0) begin
                m_mode = 1;
                m_who  = win;
            end
        end else if (m_mode != 0 && d) begin
            if (m_mode == 1) m_ack = 1 << m_who;
            m_mode = 0;
        end
        if (tick && !cons) begin
            if (m_pend < PMAX) m_pend = m_pend + 1;
        end else if (cons && !tick) begin
            m_pend = m_pend - 1;
        end
    endtask

    always @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_who = 0; m_pend = 0; m_edges = 0; m_ptr = 0;
            m_ack = 0; m_hit = 0; m_starve = '{0, 0, 0};
        end else begin
            model_step(slot_start, slot_done, req);
        end
    end

    // Continuous comparison against the model, away from the rising edge
    always @(negedge sysclk) begin
        chk("grant",           int'(grant),           (m_mode == 1) ? (1 << m_who) : 0);
        chk("grant_refresh",   int'(grant_refresh),   (m_mode == 2) ? 1 : 0);
        chk("busy",            int'(busy),            (m_mode != 0) ? 1 : 0);
        chk("ack",             int'(ack),             m_ack);
        chk("refresh_pending", int'(refresh_pending), m_pend);
        chk("starve_hit",      int'(starve_hit),      m_hit);
    end

    task automatic do_reset();
        @(negedge sysclk);
        reset_n    = 1'b0;
        slot_start = 1'b0;
        slot_done  = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic run_slot(input logic [3:0] r, input int hold,
                            output logic [3:0] g, output logic h,
                            output logic rf, output logic [3:0] a);
        @(negedge sysclk);
        req        = r;
        slot_start = 1'b1;
        @(negedge sysclk);
        slot_start = 1'b0;
        g  = grant;
        h  = starve_hit;
        rf = grant_refresh;
        repeat (hold) @(negedge sysclk);
        slot_done = 1'b1;
        @(negedge sysclk);
        slot_done = 1'b0;
        a = ack;
    endtask

    task automatic wait_edges(input int target, input string tag);
        int guard;
        guard = 0;
        while (m_edges != target && guard < 500) begin
            @(negedge sysclk);
            guard++;
        end
        if (guard >= 500) chk(tag, m_edges, target);
    endtask

    initial begin
        logic [3:0] g, a;
        logic       h, rf;
        logic [3:0] base;

        // Reset state, before any clock edge
        #1 reset_n = 1'b0;
        #2;
        chk("rst_grant",   int'(grant),           0);
        chk("rst_busy",    int'(busy),            0);
        chk("rst_refresh", int'(grant_refresh),   0);
        chk("rst_pending", int'(refresh_pending), 0);
        chk("rst_ack",     int'(ack),             0);
        do_reset();

        // Round-robin fairness
        for (int k = 0; k < 10; k++) begin
            run_slot(4'b0111, 1, g, h, rf, a);
            chk("rr_grant", int'(g), 1 << (k % 3));
            chk("rr_ack",   int'(a), 1 << (k % 3));
        end

        // Audio priority then starvation promotion of cpu
        do_reset();
        for (int k = 0; k < 8; k++) begin
            run_slot(4'b1001, 0, g, h, rf, a);
            chk("starve_grant", int'(g), (k == 6) ? 4'b0001 : 4'b1000);
            chk("starve_hit",   int'(h), (k == 6) ? 1 : 0);
        end

        // Request drop during a host grant
        do_reset();
        @(negedge sysclk);
        req = 4'b0010; slot_start = 1'b1;
        @(negedge sysclk);
        slot_start = 1'b0; req = 4'b0000;
        chk("drop_grant0", int'(grant), 4'b0010);
        for (int k = 0; k < 3; k++) begin
            @(negedge sysclk);
            chk("drop_hold", int'(grant), 4'b0010);
        end
        slot_done = 1'b1;
        @(negedge sysclk);
        slot_done = 1'b0;
        chk("drop_ack", int'(ack), 4'b0010);

        // slot_done and slot_start together: no new grant
        @(negedge sysclk);
        req = 4'b0001; slot_start = 1'b1;
        @(negedge sysclk);
        slot_start = 1'b0;
        chk("ovl_grant", int'(grant), 4'b0001);
        slot_done = 1'b1; slot_start = 1'b1;
        @(negedge sysclk);
        slot_done = 1'b0; slot_start = 1'b0;
        chk("ovl_grant_after", int'(grant), 0);
        chk("ovl_busy_after",  int'(busy),  0);
        @(negedge sysclk);
        chk("ovl_still_idle",  int'(busy),  0);

        // Reset in the middle of a cpu slot
        @(negedge sysclk);
        req = 4'b0001; slot_start = 1'b1;
        @(negedge sysclk);
        slot_start = 1'b0;
        chk("mid_grant", int'(grant), 4'b0001);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_busy",  int'(busy),  0);
        #1 reset_n = 1'b1;
        run_slot(4'b0001, 0, g, h, rf, a);
        chk("post_rst_grant", int'(g), 4'b0001);

        // Refresh urgency: four ticks with no decisions
        do_reset();
        req = 4'b1111;
        wait_edges(64, "urg_wait");
        chk("urg_pending4", int'(refresh_pending), 4);
        slot_start = 1'b1;
        @(negedge sysclk);
        slot_start = 1'b0;
        chk("urg_refresh", int'(grant_refresh),   1);
        chk("urg_grant",   int'(grant),           0);
        chk("urg_pending", int'(refresh_pending), 3);
        slot_done = 1'b1;
        @(negedge sysclk);
        slot_done = 1'b0;
        chk("urg_no_ack", int'(ack), 0);

        // Idle refresh whose decision collides with a tick
        do_reset();
        req = 4'b0000;
        wait_edges(31, "tick_wait");
        chk("tick_pending1", int'(refresh_pending), 1);
        slot_start = 1'b1;
        @(negedge sysclk);
        slot_start = 1'b0;
        chk("tick_refresh", int'(grant_refresh),   1);
        chk("tick_pending", int'(refresh_pending), 1);
        slot_done = 1'b1;
        @(negedge sysclk);
        slot_done = 1'b0;

        // Randomized traffic, checked every cycle against the model
        base = 4'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            @(negedge sysclk);
            if ((i % 40) == 0) base = 4'($urandom);
            req        = base ^ (($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);
            slot_start = ($urandom_range(0, 2) == 0);
            slot_done  = ($urandom_range(0, 3) == 0);
        end
        @(negedge sysclk);
        slot_start = 1'b0;
        slot_done  = 1'b0;
        @(negedge sysclk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
